write_back_buffer: RTL and testbench
====================================

Name: write_back_buffer

Overview:
- Write-through drain stage downstream of the set-associative cache.
- Queues every cache write (address + data) and drains it to main RAM over a req/ack handshake, so the cache never stalls on RAM write latency.
- Provides store-to-load forwarding: on a cache read miss, a pending buffered write to the same address supplies the fill data instead of stale RAM data.

Parameters:
- DATA_WIDTH, 32, width of each data word.
- ADDR_WIDTH, 6, width of the tag + set-index address.
- DEPTH, 4, number of entries; must be a power of two and at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  cache presents a write.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_ready  out  1  buffer can accept a write; equals !full.
- mem_req  out  1  write request to RAM (registered).
- mem_addr  out  ADDR_WIDTH  head entry address.
- mem_wdata  out  DATA_WIDTH  head entry data.
- mem_ack  in  1  RAM accepted the current request; single-cycle pulse.
- lookup_addr  in  ADDR_WIDTH  cache miss address to check.
- lookup_hit  out  1  a pending entry matches lookup_addr (combinational).
- lookup_data  out  DATA_WIDTH  data of the youngest matching entry; 0 when no hit.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- Reset (asynchronous, active-low):
  - Pointers and count go to 0; all entry valid bits clear; FSM goes to IDLE.
  - mem_req = 0, empty = 1, full = 0, wr_ready = 1, lookup_hit = 0.
  - Pending writes are discarded. mem_req drops immediately even mid-handshake.
- Push:
  - Occurs on a rising edge with wr_valid && wr_ready. The entry is written at wr_ptr, and wr_ptr increments modulo DEPTH.
  - A write offered while full is ignored (not stored). The cache must hold it.
- FSM states:
  - IDLE: mem_req = 0. If !empty, go to REQ next cycle. Push-to-request latency is 1 cycle minimum (push at edge N, mem_req high after edge N+1).
  - REQ: mem_req = 1. mem_addr/mem_wdata are driven from the head entry and held stable until mem_ack.
  - On mem_ack in REQ: pop the head (rd_ptr increments modulo DEPTH).
    - If entries remain after the pop, including one pushed in the same cycle, stay in REQ with the next head presented on the following cycle (back-to-back drain).
    - Otherwise go to IDLE.
  - mem_ack in IDLE is ignored.
- Count rules:
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pop only: count - 1. Push only: count + 1.
- Pointers: $clog2(DEPTH) bits each, natural wrap. full/empty are derived from count, never from pointer equality alone.
- Forwarding:
  - Scan all valid entries. lookup_hit = 1 if any entry address equals lookup_addr.
  - lookup_data is taken from the youngest match, ordered from wr_ptr-1 backwards.
  - The head entry remains forwardable during its ack cycle. An entry pushed in the current cycle is not visible until the next cycle.
- Ordering: RAM sees writes in push order.

Optional Feature:
- Macro: WBUF_COALESCE_EN.
- Defined: a push whose wr_addr matches a valid non-head entry overwrites that entry's data in place. No allocation, count unchanged. This push is accepted even when full (wr_ready = !full || coalesce_match).
  - The head entry is never coalesced while in REQ, because its bus values must stay stable.
  - If multiple entries match, the youngest is updated.
- Not defined: every push allocates a new entry; wr_ready = !full.

Decomposition:
- Shared package (cache_pkg):
  - DATA_WIDTH, ADDR_WIDTH, DEPTH defaults.
  - wbuf_entry_t struct {valid, addr, data}.
  - wbuf_state_t enum {IDLE, REQ}.
- One natural sub-module: wbuf_forward_match, a combinational youngest-match priority scan over the entry array producing lookup_hit/lookup_data; reused by the coalescing logic.

Test Plan:
- Reset mid-drain: push addr 0x05/data 0xA5A5A5A5; assert rst_n = 0 while mem_req = 1 -> mem_req drops in the same cycle, count = 0, empty = 1, no mem_req after release.
- Fill and backpressure: push 4 writes (0x01..0x04, data 0x11..0x44) with mem_ack held low -> full = 1, wr_ready = 0; a 5th push is dropped and count stays 4.
- Drain order: ack each request with 2-cycle RAM latency -> mem_addr sequence 0x01, 0x02, 0x03, 0x04; mem_req stays high between acks; IDLE with empty = 1 after the last ack.
- Simultaneous push/pop at count = 1: ack the head while pushing 0x09 -> count stays 1, mem_req stays 1, next mem_addr = 0x09.
- Forwarding: push 0x0A/0x100, then 0x0A/0x200 with no ack -> lookup_addr 0x0A gives lookup_hit = 1, lookup_data = 0x200; lookup_addr 0x0B gives lookup_hit = 0, lookup_data = 0.
- WBUF_COALESCE_EN: head 0x01 in REQ, entry 0x0A/0x100 queued behind it; push 0x0A/0x300 -> count unchanged, RAM eventually receives 0x0A/0x300 exactly once. A push to the head address 0x01 allocates a new entry.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the write-back buffer: default geometry, the entry
// record layout and the drain FSM state encoding.
package cache_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 6;
  localparam int DEFAULT_DEPTH      = 4;

  // One buffered write as it sits in the queue.
  typedef struct packed {
    logic                          valid;
    logic [DEFAULT_ADDR_WIDTH-1:0] addr;
    logic [DEFAULT_DATA_WIDTH-1:0] data;
  } wbuf_entry_t;

  // Drain FSM: IDLE has nothing on the RAM bus, REQ holds the head entry there.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } wbuf_state_t;

endpackage

// File: rtl/wbuf_forward_match.sv
// Youngest-match priority scan over the buffer entries. Walks the slots from
// the oldest position (wr_ptr) to the youngest (wr_ptr-1) so that the last
// match found is the youngest one. Slots set in the exclude mask are skipped.
module wbuf_forward_match #(
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]      valid,
  input  logic [DEPTH-1:0]      exclude,
  input  logic [ADDR_WIDTH-1:0] addrs [DEPTH],
  input  logic [PTR_W-1:0]      wr_ptr,
  input  logic [ADDR_WIDTH-1:0] match_addr,
  output logic                  hit,
  output logic [PTR_W-1:0]      idx
);

  logic [PTR_W-1:0] slot;

  // Priority scan, oldest to youngest; later matches override earlier ones.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    hit  = 1'b0;
    idx  = wr_ptr;
    slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = wr_ptr + PTR_W'(i);
      if (valid[slot] && !exclude[slot] && (addrs[slot] == match_addr)) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end

endmodule

// File: rtl/write_back_buffer.sv
// Write-through drain buffer between the cache and main RAM. Queues cache
// writes, drains them in order over a req/ack handshake and forwards pending
// data to cache read misses.
// Optional build macro WBUF_COALESCE_EN: a write hitting a queued non-head
// entry updates that entry's data in place instead of allocating.
module write_back_buffer
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  input  logic [ADDR_WIDTH-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       wr_ready,
  output logic                       mem_req,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic                       mem_ack,
  input  logic [ADDR_WIDTH-1:0]      lookup_addr,
  output logic                       lookup_hit,
  output logic [DATA_WIDTH-1:0]      lookup_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_REQ  = REQ;

  logic [DEPTH-1:0]      valid;
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [0:0]            state;
  logic [0:0]            state_next;
  logic                  push;
  logic                  pop;
  logic                  coalesce;
  logic                  fwd_hit;
  logic [PTR_W-1:0]      fwd_idx;
  logic [PTR_W-1:0]      co_idx;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign mem_req   = (state == S_REQ);
  assign mem_addr  = addr_mem[rd_ptr];
  assign mem_wdata = data_mem[rd_ptr];
  assign pop       = mem_req && mem_ack;
  assign push      = wr_valid && wr_ready && !coalesce;

  wbuf_forward_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_forward (
    .valid      (valid),
    .exclude    ({DEPTH{1'b0}}),
    .addrs      (addr_mem),
    .wr_ptr     (wr_ptr),
    .match_addr (lookup_addr),
    .hit        (fwd_hit),
    .idx        (fwd_idx)
  );

  assign lookup_hit  = fwd_hit;
  assign lookup_data = fwd_hit ? data_mem[fwd_idx] : '0;

`ifdef WBUF_COALESCE_EN
  logic             co_hit;
  logic [DEPTH-1:0] head_mask;

  // The head is excluded so the values on the RAM bus never change under a request.
  assign head_mask = {{(DEPTH-1){1'b0}}, 1'b1} << rd_ptr;

  wbuf_forward_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_coalesce (
    .valid      (valid),
    .exclude    (head_mask),
    .addrs      (addr_mem),
    .wr_ptr     (wr_ptr),
    .match_addr (wr_addr),
    .hit        (co_hit),
    .idx        (co_idx)
  );

  assign coalesce = wr_valid && co_hit;
  assign wr_ready = !full || coalesce;
`else
  assign coalesce = 1'b0;
  assign co_idx   = '0;
  assign wr_ready = !full;
`endif

  // Drain FSM next state: request while anything is queued, drop after the last ack.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (!empty) state_next = S_REQ;
      S_REQ:   if (pop && (count == CNT_W'(1)) && !push) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Control state: pointers, occupancy, valid bits and FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
      state  <= S_IDLE;
    end else begin
      state <= state_next;
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        valid[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr        <= wr_ptr + 1'b1;
        valid[wr_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload storage, written on allocation or in-place coalescing.
  // NOTE: the payload array has no reset; the valid bits alone decide whether
  // a slot's contents mean anything, so resetting it would only cost logic.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= wr_addr;
      data_mem[wr_ptr] <= wr_data;
    end
    if (coalesce) begin
      data_mem[co_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_write_back_buffer.sv
// Self-checking bench for write_back_buffer: reset mid-drain, a table of
// per-cycle vectors (fill, backpressure, drain, push/pop overlap, forwarding)
// and hand-written sequences for ack-cycle forwarding and coalescing.
module tb_write_back_buffer;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        mem_req;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [5:0]  lookup_addr;
  logic        lookup_hit;
  logic [31:0] lookup_data;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  int n_checks = 0;
  int n_fail   = 0;

  write_back_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .lookup_addr (lookup_addr),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .count       (count),
    .empty       (empty),
    .full        (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wv;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic        ack;
    logic [5:0]  la;
    int          cnt;
    logic        req;
    logic [5:0]  ma;
    logic [31:0] md;
    logic        hit;
    logic [31:0] ld;
  } vec_t;

  vec_t vecs [24];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one cycle and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait up to max_cycles for mem_req; an expired wait counts as a failure.
  task automatic wait_req(input int max_cycles, input string name);
    int n;
    n = 0;
    while (!mem_req && n < max_cycles) begin
      tick();
      n++;
    end
    check({name, "_req_timeout"}, 64'(mem_req), 64'd1);
  endtask

  task automatic push_one(input logic [5:0] a, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    // wv wa     wd            ack la     cnt req ma     md            hit ld
    vecs[0]  = '{1, 6'h01, 32'h11,  0, 6'h01, 1, 0, 6'h00, 32'h0,   1, 32'h11};
    vecs[1]  = '{1, 6'h02, 32'h22,  0, 6'h01, 2, 1, 6'h01, 32'h11,  1, 32'h11};
    vecs[2]  = '{1, 6'h03, 32'h33,  0, 6'h03, 3, 1, 6'h01, 32'h11,  1, 32'h33};
    vecs[3]  = '{1, 6'h04, 32'h44,  0, 6'h02, 4, 1, 6'h01, 32'h11,  1, 32'h22};
    vecs[4]  = '{1, 6'h05, 32'h55,  0, 6'h05, 4, 1, 6'h01, 32'h11,  0, 32'h0};
    vecs[5]  = '{0, 6'h00, 32'h0,   0, 6'h05, 4, 1, 6'h01, 32'h11,  0, 32'h0};
    vecs[6]  = '{0, 6'h00, 32'h0,   1, 6'h01, 3, 1, 6'h02, 32'h22,  0, 32'h0};
    vecs[7]  = '{0, 6'h00, 32'h0,   0, 6'h02, 3, 1, 6'h02, 32'h22,  1, 32'h22};
    vecs[8]  = '{0, 6'h00, 32'h0,   1, 6'h03, 2, 1, 6'h03, 32'h33,  1, 32'h33};
    vecs[9]  = '{0, 6'h00, 32'h0,   0, 6'h03, 2, 1, 6'h03, 32'h33,  1, 32'h33};
    vecs[10] = '{0, 6'h00, 32'h0,   1, 6'h04, 1, 1, 6'h04, 32'h44,  1, 32'h44};
    vecs[11] = '{0, 6'h00, 32'h0,   0, 6'h04, 1, 1, 6'h04, 32'h44,  1, 32'h44};
    vecs[12] = '{1, 6'h09, 32'h99,  1, 6'h09, 1, 1, 6'h09, 32'h99,  1, 32'h99};
    vecs[13] = '{0, 6'h00, 32'h0,   0, 6'h04, 1, 1, 6'h09, 32'h99,  0, 32'h0};
    vecs[14] = '{0, 6'h00, 32'h0,   1, 6'h09, 0, 0, 6'h00, 32'h0,   0, 32'h0};
    vecs[15] = '{1, 6'h0A, 32'h100, 0, 6'h0A, 1, 0, 6'h00, 32'h0,   1, 32'h100};
    vecs[16] = '{1, 6'h0A, 32'h200, 0, 6'h0A, 2, 1, 6'h0A, 32'h100, 1, 32'h200};
    vecs[17] = '{0, 6'h00, 32'h0,   0, 6'h0B, 2, 1, 6'h0A, 32'h100, 0, 32'h0};
    vecs[18] = '{0, 6'h00, 32'h0,   1, 6'h0A, 1, 1, 6'h0A, 32'h200, 1, 32'h200};
    vecs[19] = '{0, 6'h00, 32'h0,   1, 6'h0A, 0, 0, 6'h00, 32'h0,   0, 32'h0};
    vecs[20] = '{0, 6'h00, 32'h0,   1, 6'h00, 0, 0, 6'h00, 32'h0,   0, 32'h0};
    vecs[21] = '{1, 6'h07, 32'h77,  1, 6'h07, 1, 0, 6'h00, 32'h0,   1, 32'h77};
    vecs[22] = '{0, 6'h00, 32'h0,   0, 6'h07, 1, 1, 6'h07, 32'h77,  1, 32'h77};
    vecs[23] = '{0, 6'h00, 32'h0,   1, 6'h07, 0, 0, 6'h00, 32'h0,   0, 32'h0};

    rst_n       = 1'b0;
    wr_valid    = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    mem_ack     = 1'b0;
    lookup_addr = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_lookup_hit", 64'(lookup_hit), 64'd0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a drain: mem_req must drop without a clock edge
    lookup_addr = 6'h05;
    push_one(6'h05, 32'hA5A5_A5A5);
    wait_req(5, "middrain");
    #2;
    rst_n = 1'b0;
    #1;
    check("middrain_req_drop", 64'(mem_req), 64'd0);
    check("middrain_count", 64'(count), 64'd0);
    check("middrain_empty", 64'(empty), 64'd1);
    check("middrain_hit", 64'(lookup_hit), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("postrst_no_req", 64'(mem_req), 64'd0);
    end

    // Table-driven cycles
    for (int i = 0; i < 24; i++) begin
      wr_valid    = vecs[i].wv;
      wr_addr     = vecs[i].wa;
      wr_data     = vecs[i].wd;
      mem_ack     = vecs[i].ack;
      lookup_addr = vecs[i].la;
      tick();
      wr_valid = 1'b0;
      mem_ack  = 1'b0;
      #1;
      check($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].cnt));
      check($sformatf("v%0d_empty", i), 64'(empty), 64'(vecs[i].cnt == 0));
      check($sformatf("v%0d_full", i), 64'(full), 64'(vecs[i].cnt == 4));
      check($sformatf("v%0d_wr_ready", i), 64'(wr_ready), 64'(vecs[i].cnt != 4));
      check($sformatf("v%0d_mem_req", i), 64'(mem_req), 64'(vecs[i].req));
      check($sformatf("v%0d_hit", i), 64'(lookup_hit), 64'(vecs[i].hit));
      check($sformatf("v%0d_lookup_data", i), 64'(lookup_data), 64'(vecs[i].ld));
      if (vecs[i].req) begin
        check($sformatf("v%0d_mem_addr", i), 64'(mem_addr), 64'(vecs[i].ma));
        check($sformatf("v%0d_mem_wdata", i), 64'(mem_wdata), 64'(vecs[i].md));
      end
    end

    // Head stays forwardable in its ack cycle; a same-cycle push is not yet visible
    lookup_addr = 6'h0C;
    push_one(6'h0C, 32'hCC);
    wait_req(5, "ackfwd");
    mem_ack = 1'b1;
    #1;
    check("ackfwd_head_hit", 64'(lookup_hit), 64'd1);
    check("ackfwd_head_data", 64'(lookup_data), 64'hCC);
    tick();
    mem_ack = 1'b0;
    #1;
    check("ackfwd_after_pop_hit", 64'(lookup_hit), 64'd0);
    wr_valid    = 1'b1;
    wr_addr     = 6'h0D;
    wr_data     = 32'hDD;
    lookup_addr = 6'h0D;
    #1;
    check("samecycle_push_hidden", 64'(lookup_hit), 64'd0);
    tick();
    wr_valid = 1'b0;
    #1;
    check("nextcycle_push_visible", 64'(lookup_data), 64'hDD);
    wait_req(5, "drain_0d");
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    check("drain_0d_empty", 64'(empty), 64'd1);

`ifdef WBUF_COALESCE_EN
    // Coalescing: non-head match updates in place; head address allocates anew
    begin
      logic [5:0]  exp_a [3];
      logic [31:0] exp_d [3];
      exp_a[0] = 6'h01; exp_d[0] = 32'h1;
      exp_a[1] = 6'h0A; exp_d[1] = 32'h300;
      exp_a[2] = 6'h01; exp_d[2] = 32'h55;
      push_one(6'h01, 32'h1);
      push_one(6'h0A, 32'h100);
      check("co_req_before", 64'(mem_req), 64'd1);
      push_one(6'h0A, 32'h300);
      check("co_count_unchanged", 64'(count), 64'd2);
      push_one(6'h01, 32'h55);
      check("co_head_alloc", 64'(count), 64'd3);
      for (int k = 0; k < 3; k++) begin
        wait_req(5, "co_drain");
        check($sformatf("co_addr%0d", k), 64'(mem_addr), 64'(exp_a[k]));
        check($sformatf("co_data%0d", k), 64'(mem_wdata), 64'(exp_d[k]));
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
        tick();
        check("co_no_extra_req", 64'(mem_req), 64'd0);
      end
      check("co_final_count", 64'(count), 64'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
